// File: rtl/serdes_pkg.sv
// Shared serdes definitions: frame-size defaults and the receive/transmit FSM state type.
package serdes_pkg;

  localparam int unsigned MAX_BITS_DEF = 2401;
  localparam int unsigned LEN_W_DEF    = 33;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel frame assembler with a single-entry output slot and
// valid/ready handoff; frames that arrive while the slot is held are dropped.
module deserializer
  import serdes_pkg::*;
#(
  parameter int unsigned MAX_BITS = MAX_BITS_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  input  logic                serial_valid,
  output logic [MAX_BITS-1:0] data_out,
  output logic [LEN_W-1:0]    length_out,
  output logic                trunc_out,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  state_e              state_q;
  logic [MAX_BITS-1:0] buf_q;
  logic [LEN_W-1:0]    count_q;
  logic                trunc_q;
  logic [MAX_BITS-1:0] data_q;
  logic [LEN_W-1:0]    length_q;
  logic                trunc_out_q;
  logic                valid_q;
  logic                overrun_q;
  logic                busy_q;

  logic                slot_free;
  logic                room;

  // The slot can take a frame if empty or being drained on this same edge.
  assign slot_free = !valid_q || frame_ready;
  assign room      = (count_q < LEN_W'(MAX_BITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      data_q      <= '0;
      length_q    <= '0;
      trunc_out_q <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && frame_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (serial_valid) begin
            // Clearing the buffer keeps bits above the frame length at zero.
            buf_q   <= MAX_BITS'(serial_in);
            count_q <= LEN_W'(1);
            trunc_q <= 1'b0;
            state_q <= RECV;
            busy_q  <= 1'b1;
          end
        end

        RECV: begin
          if (serial_valid) begin
            if (room) begin
              buf_q[count_q[IDX_W-1:0]] <= serial_in;
              count_q                   <= count_q + LEN_W'(1);
            end else begin
              trunc_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (slot_free) begin
              data_q      <= buf_q;
              length_q    <= count_q;
              trunc_out_q <= trunc_q;
              valid_q     <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = data_q;
  assign length_out  = length_q;
  assign trunc_out   = trunc_out_q;
  assign frame_valid = valid_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter MAX_BITS, default 2401, is the frame buffer capacity in bits.
REQ-002 Parameter LEN_W, default 33, is the width of the length field.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 serial_in  input  1  serial data bit, LSB of frame first.
REQ-006 serial_valid  input  1  high while serial_in carries a frame bit; one bit per cycle; low = inter-frame gap.
REQ-007 data_out  output  MAX_BITS  assembled frame; bit k = k-th received bit.
REQ-008 length_out  output  LEN_W  number of bits stored in data_out.
REQ-009 trunc_out  output  1  frame exceeded MAX_BITS; excess bits were discarded.
REQ-010 frame_valid  output  1  data_out/length_out/trunc_out hold a complete frame.
REQ-011 frame_ready  input  1  consumer accepts the frame on a cycle where frame_valid is also high.
REQ-012 overrun  output  1  one-cycle pulse: a completed frame was dropped.
REQ-013 busy  output  1  high while in RECV.

Function
REQ-014 FSM states SHALL be IDLE and RECV; internal assembly buffer, bit counter (LEN_W bits) and truncation flag are separate from the output slot.
REQ-015 IDLE, serial_valid=1: assembly buffer <= all zeros except bit0=serial_in; count<=1; trunc<=0; go RECV.
REQ-016 IDLE, serial_valid=0: no state change.
REQ-017 RECV, serial_valid=1, count<MAX_BITS: buffer[count]<=serial_in; count<=count+1.
REQ-018 RECV, serial_valid=1, count==MAX_BITS: bit discarded, count holds, trunc<=1.
REQ-019 RECV, serial_valid=0: frame ends; go IDLE in the same edge.
REQ-020 At frame end, if the output slot is free (frame_valid=0, or frame_valid=1 with frame_ready=1 in that cycle), the slot SHALL load buffer, count and trunc, and frame_valid SHALL be 1 after that edge.
REQ-021 At frame end with frame_valid=1 and frame_ready=0: the frame is dropped, the slot is unchanged, and overrun=1 for exactly the next cycle.
REQ-022 Latency: last bit sampled at edge N, serial_valid=0 sampled at edge N+1, frame_valid high after edge N+1.
REQ-023 Frames are separated by at least one cycle with serial_valid=0; a serial_valid=1 sampled in IDLE always starts a new frame.
REQ-024 The slot outputs SHALL be stable while frame_valid=1 and frame_ready=0.
REQ-025 frame_valid clears on an edge with frame_ready=1, unless a new frame loads at the same edge, in which case it stays 1 with the new contents.
REQ-026 Bits of data_out at index >= length_out SHALL read 0.
REQ-027 frame_ready while frame_valid=0 has no effect.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE; count, buffer, trunc, data_out, length_out, trunc_out, frame_valid and overrun = 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; no frame_valid results from it.

Structure
REQ-030 Package serdes_pkg SHALL hold the MAX_BITS and LEN_W defaults and the FSM state enum, for sharing with the transmit serializer.
REQ-031 The block is a single module; no sub-module is required.

Verification
REQ-032 Send 8 bits 1,0,1,1,0,0,0,1 then gap, frame_ready=1 -> after gap edge: frame_valid=1, data_out[7:0]=0x8D, length_out=8, trunc_out=0; cleared next cycle.
REQ-033 Send 1-bit frame "1" -> length_out=1, data_out=1; then send 3-bit frame 0,0,0 -> data_out=0 (no residue from the prior frame).
REQ-034 MAX_BITS=16, send 20 ones -> length_out=16, data_out[15:0]=0xFFFF, trunc_out=1.
REQ-035 frame_ready=0, send two frames -> first frame held intact, overrun pulses one cycle at the second frame end; frame_ready=1 then accepts the first frame only.
REQ-036 Slot full, frame_ready=1 in the same cycle a second frame ends -> frame_valid stays 1 with the second frame, no overrun.
REQ-037 Assert rst after 5 bits of a frame -> busy=0 and frame_valid=0 immediately; the next frame of 4 bits reports length_out=4.
